// File: rtl/float_pkg.sv
// Shared definitions for the float operator and its result buffer.
package float_pkg;

    localparam int FLOAT_WIDTH = 32;

    // Operation codes understood by the upstream float operator.
    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_DIV  = 3'd3,
        OP_LESS = 3'd4
    } float_op_e;

    // Bits needed to hold a count from 0 to depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/float_result_buffer_fifo_mem.sv
// DEPTH x WIDTH storage for the result buffer: one write port, asynchronous read port.
module fifo_mem
    import float_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = FLOAT_WIDTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    // Storage is deliberately not reset; validity is tracked by the count.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/float_result_buffer.sv
// Catches every result pulse from the fixed-latency float operator and hands it
// to the consumer over valid/ready, granting issue credits so the FIFO cannot overflow.
module float_result_buffer
    import float_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int LATENCY = 5,
    parameter int WIDTH   = FLOAT_WIDTH,
    localparam int CW     = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    output logic             issue_ok,
    input  logic             done,
    input  logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    inflight,
    output logic             overflow,
    output logic             issue_err
);

    localparam int AW                = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_inflight;
    logic          r_overflow;
    logic          r_issue_err;

    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_issue_ok;
    logic [CW:0]   w_occupancy;
    logic [CW-1:0] w_count_nxt;
    logic [CW-1:0] w_inflight_nxt;
    logic [WIDTH-1:0] w_rdata;

    // Consumer handshake: a word transfers on every rising edge where out_valid
    // and out_ready are both high; out_valid never looks at out_ready, and
    // out_data holds the same head word while out_valid && !out_ready.
    assign w_full = (r_count == DEPTH_C);
    assign w_pop  = (r_count != '0) && out_ready;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_push = done && (!w_full || w_pop);
    assign w_drop = done && w_full && !w_pop;

    // Credit uses registered state only, so a same-cycle pop earns nothing yet.
    assign w_occupancy = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_issue_ok  = (w_occupancy < {1'b0, DEPTH_C});

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + ONE_C;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - ONE_C;
        end
    end

    // Saturate at zero for orphan dones that drain out after a reset.
    always_comb begin
        w_inflight_nxt = r_inflight;
        if (issue && !done && (r_inflight != DEPTH_C)) begin
            w_inflight_nxt = r_inflight + ONE_C;
        end else if (done && !issue && (r_inflight != '0)) begin
            w_inflight_nxt = r_inflight - ONE_C;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_inflight  <= '0;
            r_overflow  <= 1'b0;
            r_issue_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count    <= w_count_nxt;
            r_inflight <= w_inflight_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (issue && !w_issue_ok) begin
                r_issue_err <= 1'b1;
            end
        end
    end

    // Wrap-by-overflow of the pointers relies on DEPTH being a power of two.
    always_ff @(posedge clk) begin
        assert (LATENCY >= 1 && DEPTH >= 2 && (DEPTH & (DEPTH - 1)) == 0);
    end

    fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (result),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign issue_ok  = w_issue_ok;
    assign out_valid = (r_count != '0);
    assign out_data  = w_rdata;
    assign count     = r_count;
    assign inflight  = r_inflight;
    assign overflow  = r_overflow;
    assign issue_err = r_issue_err;

endmodule

// File: tb/tb_float_result_buffer.sv
// Self-checking bench for float_result_buffer with DEPTH=4, LATENCY=5.
module tb_float_result_buffer;

    localparam int DEPTH   = 4;
    localparam int LATENCY = 5;
    localparam int W       = 32;
    localparam int CW      = 3;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic          issue;
    logic          issue_ok;
    logic          done;
    logic [W-1:0]  result;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic          overflow;
    logic          issue_err;

    always #5 clk = ~clk;

    float_result_buffer #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY),
        .WIDTH   (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (issue),
        .issue_ok  (issue_ok),
        .done      (done),
        .result    (result),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .inflight  (inflight),
        .overflow  (overflow),
        .issue_err (issue_err)
    );

    // ---------------- operator model: every issue returns LATENCY cycles later ----------------
    bit           pipe_v [LATENCY];
    logic [W-1:0] pipe_d [LATENCY];

    // ---------------- scoreboard / reference model ----------------
    logic [W-1:0] exp_q[$];
    int           m_inflight;
    bit           m_ovf;
    bit           m_ierr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit           iss;
        bit           rdy;
        bit           e_valid;
        logic [W-1:0] e_data;
        int           e_count;
        int           e_inflight;
        bit           e_ok;
    } vec_t;

    vec_t basic_tbl [8];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ok();
        return (exp_q.size() + m_inflight) < DEPTH;
    endfunction

    task automatic check_outputs();
        check("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check("out_data", out_data, exp_q[0]);
        check("count", count, exp_q.size());
        check("inflight", inflight, m_inflight);
        check("issue_ok", issue_ok, model_ok());
        check("overflow", overflow, m_ovf);
        check("issue_err", issue_err, m_ierr);
    endtask

    task automatic shift_pipe(input bit iss, input logic [W-1:0] d);
        for (int i = LATENCY - 1; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_d[i] = pipe_d[i-1];
        end
        pipe_v[0] = iss;
        pipe_d[0] = d;
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_inflight = 0;
        m_ovf      = 1'b0;
        m_ierr     = 1'b0;
    endtask

    // ---------------- driver: one clock cycle, entered and left at a negedge ----------------
    task automatic cycle(input bit iss, input logic [W-1:0] idata, input bit rdy,
                         input bit fdone, input logic [W-1:0] fdata);
        bit           dn;
        logic [W-1:0] dd;
        bit           pop;
        bit           accept;
        check_outputs();
        dn = pipe_v[LATENCY-1] || fdone;
        dd = fdone ? fdata : pipe_d[LATENCY-1];
        issue     = iss;
        out_ready = rdy;
        done      = dn;
        result    = dn ? dd : $urandom();
        pop    = (exp_q.size() != 0) && rdy;
        accept = (exp_q.size() < DEPTH) || pop;
        if (iss && !model_ok()) m_ierr = 1'b1;
        if (pop) void'(exp_q.pop_front());
        if (dn && accept) exp_q.push_back(dd);
        if (dn && !accept) m_ovf = 1'b1;
        if (iss && !dn && m_inflight < DEPTH) m_inflight++;
        else if (dn && !iss && m_inflight > 0) m_inflight--;
        shift_pipe(iss, idata);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle while operations are in flight.
    task automatic reset_cycle();
        issue     = 1'b0;
        out_ready = 1'b0;
        done      = pipe_v[LATENCY-1];
        result    = pipe_d[LATENCY-1];
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_inflight", inflight, 0);
        check("rst_overflow", overflow, 0);
        check("rst_issue_err", issue_err, 0);
        check("rst_issue_ok", issue_ok, 1);
        model_clear();
        shift_pipe(1'b0, '0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int           n_iss;
        logic [W-1:0] last_seen;

        issue = 0; done = 0; result = '0; out_ready = 0; rst_n = 0;
        for (int i = 0; i < LATENCY; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = '0;
        end
        model_clear();
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Basic: issue at cycle 0, result at cycle 5, visible at 6, popped by 7.
        basic_tbl[0] = '{1, 1, 0, 32'h0,        0, 0, 1};
        basic_tbl[1] = '{0, 1, 0, 32'h0,        0, 1, 1};
        basic_tbl[2] = '{0, 1, 0, 32'h0,        0, 1, 1};
        basic_tbl[3] = '{0, 1, 0, 32'h0,        0, 1, 1};
        basic_tbl[4] = '{0, 1, 0, 32'h0,        0, 1, 1};
        basic_tbl[5] = '{0, 1, 0, 32'h0,        0, 1, 1};
        basic_tbl[6] = '{0, 1, 1, 32'h40400000, 1, 0, 1};
        basic_tbl[7] = '{0, 1, 0, 32'h0,        0, 0, 1};
        for (int i = 0; i < 8; i++) begin
            check("basic_valid", out_valid, basic_tbl[i].e_valid);
            if (basic_tbl[i].e_valid) check("basic_data", out_data, basic_tbl[i].e_data);
            check("basic_count", count, basic_tbl[i].e_count);
            check("basic_inflight", inflight, basic_tbl[i].e_inflight);
            check("basic_issue_ok", issue_ok, basic_tbl[i].e_ok);
            cycle(basic_tbl[i].iss, 32'h40400000, basic_tbl[i].rdy, 1'b0, '0);
        end

        // Credit limit: consumer stalled, issue whenever the DUT grants credit.
        n_iss = 0;
        for (int c = 0; c < 12; c++) begin
            bit go;
            go = issue_ok;
            if (c == 4) check("credit_ok_at_4", issue_ok, 0);
            if (go) n_iss++;
            cycle(go, $urandom(), 1'b0, 1'b0, '0);
        end
        check("credit_issues", n_iss, 4);
        check("credit_count", count, 4);
        check("credit_inflight", inflight, 0);
        check("credit_overflow", overflow, 0);

        // Full with simultaneous push and pop.
        cycle(1'b0, '0, 1'b1, 1'b1, 32'h3F800000);
        check("fullpp_count", count, 4);
        check("fullpp_overflow", overflow, 0);
        last_seen = '0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid) last_seen = out_data;
            cycle(1'b0, '0, 1'b1, 1'b0, '0);
        end
        check("fullpp_tail", last_seen, 32'h3F800000);

        // Overflow: fill to 4 with consumer stalled, then force an extra result.
        for (int c = 0; c < 4; c++) cycle(1'b1, $urandom(), 1'b0, 1'b0, '0);
        for (int c = 0; c < 6; c++) cycle(1'b0, '0, 1'b0, 1'b0, '0);
        cycle(1'b0, '0, 1'b0, 1'b1, 32'hDEADBEEF);
        check("ovf_flag", overflow, 1);
        check("ovf_count", count, 4);

        // Illegal issue while full: flag is sticky, inflight caps at DEPTH.
        cycle(1'b1, $urandom(), 1'b0, 1'b0, '0);
        check("ierr_flag", issue_err, 1);
        for (int c = 0; c < 5; c++) cycle(1'b1, $urandom(), 1'b0, 1'b0, '0);
        check("ierr_inflight_cap", inflight, 4);
        check("ierr_sticky", issue_err, 1);
        for (int c = 0; c < 16; c++) begin
            check("ovf_never_shown", out_valid && (out_data == 32'hDEADBEEF), 0);
            cycle(1'b0, '0, 1'b1, 1'b0, '0);
        end

        // Reset mid-operation: three results in flight come back as orphans.
        for (int c = 0; c < 3; c++) cycle(1'b1, $urandom(), 1'b0, 1'b0, '0);
        reset_cycle();
        for (int c = 0; c < 8; c++) cycle(1'b0, '0, 1'b0, 1'b0, '0);
        check("orphan_count", count, 3);
        check("orphan_inflight", inflight, 0);
        for (int c = 0; c < 4; c++) cycle(1'b0, '0, 1'b1, 1'b0, '0);

        // Randomized legal traffic; results include 0/1 values as from a compare.
        for (int c = 0; c < 400; c++) begin
            bit           go;
            logic [W-1:0] d;
            go = issue_ok && ($urandom_range(0, 2) != 0);
            d  = ($urandom_range(0, 4) == 0) ? W'($urandom_range(0, 1)) : $urandom();
            cycle(go, d, $urandom_range(0, 3) != 0, 1'b0, '0);
        end
        for (int c = 0; c < LATENCY + DEPTH + 2; c++) cycle(1'b0, '0, 1'b1, 1'b0, '0);
        check("final_count", count, 0);
        check("final_overflow", overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
